// File: rtl/adpll_pkg.sv
// Shared ADPLL types and helpers: phase-detector FSM states, default error width,
// error saturation bound and a magnitude/saturation helper also used by the loop filter and DCO.
package adpll_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REF_LEAD = 2'd1,
    FB_LEAD  = 2'd2
  } phase_state_e;

  localparam int ERROR_WIDTH_DEF = 5;

  // Largest positive value of a signed word; the most negative code is never used.
  function automatic int err_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int sat_mag(input int value, input int limit);
    int mag;
    mag = (value < 0) ? -value : value;
    return (mag > limit) ? limit : mag;
  endfunction

endpackage

// File: rtl/phase_error_detector_edge_sync.sv
// Clock-input synchroniser followed by a one-flop edge history; flags a rising edge
// for one gen_clk cycle.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/phase_error_detector.sv
// Measures the gen_clk-cycle offset between reference and feedback rising edges and
// emits a signed saturated error plus a lock flag. Build option: PHASE_ERROR_HOLD_EN.
module phase_error_detector
  import adpll_pkg::*;
#(
  parameter int ERROR_WIDTH = ERROR_WIDTH_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_TOL    = 1,
  parameter int LOCK_CYCLES = 8
) (
  input  logic                          gen_clk_i,
  input  logic                          reset_i,
  input  logic                          ref_clk_i,
  input  logic                          fb_clk_i,
  output logic signed [ERROR_WIDTH-1:0] error_o,
  output logic                          error_valid_o,
  output logic                          lock_o
);

  localparam int MAX = err_max(ERROR_WIDTH);
  localparam int LW  = $clog2(LOCK_CYCLES + 1);

  localparam logic        [ERROR_WIDTH-1:0] CNT_MAX  = ERROR_WIDTH'(MAX);
  localparam logic        [ERROR_WIDTH-1:0] CNT_ONE  = ERROR_WIDTH'(1);
  localparam logic signed [ERROR_WIDTH-1:0] ERR_PMAX = ERROR_WIDTH'(MAX);
  localparam logic signed [ERROR_WIDTH-1:0] ERR_NMAX = ERROR_WIDTH'(-MAX);
  localparam logic        [LW-1:0]          LOCK_FULL = LW'(LOCK_CYCLES);

  function automatic logic [ERROR_WIDTH-1:0] cnt_inc_sat(input logic [ERROR_WIDTH-1:0] c);
    return (c >= CNT_MAX) ? CNT_MAX : c + CNT_ONE;
  endfunction

  function automatic logic in_tol(input logic signed [ERROR_WIDTH-1:0] e);
    return sat_mag(int'(e), MAX) <= LOCK_TOL;
  endfunction

  function automatic logic [LW-1:0] lock_inc_sat(input logic [LW-1:0] c);
    return (c >= LOCK_FULL) ? LOCK_FULL : c + LW'(1);
  endfunction

  logic w_ref_rise;
  logic w_fb_rise;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
    .i_clk   (gen_clk_i),
    .i_rst   (reset_i),
    .i_async (ref_clk_i),
    .o_rise  (w_ref_rise)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
    .i_clk   (gen_clk_i),
    .i_rst   (reset_i),
    .i_async (fb_clk_i),
    .o_rise  (w_fb_rise)
  );

  // Stage p0: interval FSM and lead counter
  phase_state_e                   r_state_p0;
  phase_state_e                   w_state_nxt_p0;
  logic        [ERROR_WIDTH-1:0]  r_count_p0;
  logic        [ERROR_WIDTH-1:0]  w_count_nxt_p0;
  logic                           w_meas_p0;
  logic                           w_miss_p0;
  logic signed [ERROR_WIDTH-1:0]  w_err_p0;

  always_comb begin
    w_state_nxt_p0 = r_state_p0;
    w_count_nxt_p0 = r_count_p0;
    w_meas_p0      = 1'b0;
    w_miss_p0      = 1'b0;
    w_err_p0       = '0;
    unique case (r_state_p0)
      IDLE: begin
        if (w_ref_rise && w_fb_rise) begin
          w_meas_p0 = 1'b1;
        end else if (w_ref_rise) begin
          w_state_nxt_p0 = REF_LEAD;
          w_count_nxt_p0 = CNT_ONE;
        end else if (w_fb_rise) begin
          w_state_nxt_p0 = FB_LEAD;
          w_count_nxt_p0 = CNT_ONE;
        end
      end
      REF_LEAD: begin
        if (w_fb_rise) begin
          w_meas_p0 = 1'b1;
          w_err_p0  = $signed(r_count_p0);
          if (w_ref_rise) begin
            w_count_nxt_p0 = CNT_ONE;
          end else begin
            w_state_nxt_p0 = IDLE;
            w_count_nxt_p0 = '0;
          end
        end else if (w_ref_rise) begin
          // Second ref edge before any fb edge: the fb edge was missed.
          w_meas_p0      = 1'b1;
          w_miss_p0      = 1'b1;
          w_err_p0       = ERR_PMAX;
          w_count_nxt_p0 = CNT_ONE;
        end else begin
          w_count_nxt_p0 = cnt_inc_sat(r_count_p0);
        end
      end
      FB_LEAD: begin
        if (w_ref_rise) begin
          w_meas_p0 = 1'b1;
          w_err_p0  = -$signed(r_count_p0);
          if (w_fb_rise) begin
            w_count_nxt_p0 = CNT_ONE;
          end else begin
            w_state_nxt_p0 = IDLE;
            w_count_nxt_p0 = '0;
          end
        end else if (w_fb_rise) begin
          w_meas_p0      = 1'b1;
          w_miss_p0      = 1'b1;
          w_err_p0       = ERR_NMAX;
          w_count_nxt_p0 = CNT_ONE;
        end else begin
          w_count_nxt_p0 = cnt_inc_sat(r_count_p0);
        end
      end
      default: begin
        w_state_nxt_p0 = IDLE;
        w_count_nxt_p0 = '0;
      end
    endcase
  end

  always_ff @(posedge gen_clk_i) begin
    if (reset_i) begin
      r_state_p0 <= IDLE;
      r_count_p0 <= '0;
    end else begin
      r_state_p0 <= w_state_nxt_p0;
      r_count_p0 <= w_count_nxt_p0;
    end
  end

  // Stage p1: registered measurement
  logic signed [ERROR_WIDTH-1:0] r_err_p1;
  logic                          r_vld_p1;
  logic                          r_miss_p1;

  always_ff @(posedge gen_clk_i) begin
    if (reset_i) begin
      r_err_p1  <= '0;
      r_vld_p1  <= 1'b0;
      r_miss_p1 <= 1'b0;
    end else begin
      r_vld_p1  <= w_meas_p0;
      r_miss_p1 <= w_miss_p0;
`ifdef PHASE_ERROR_HOLD_EN
      if (w_meas_p0) begin
        r_err_p1 <= w_err_p0;
      end
`else
      r_err_p1 <= w_meas_p0 ? w_err_p0 : '0;
`endif
    end
  end

  // Stage p2: lock qualification from the published measurement
  logic [LW-1:0] r_lock_cnt_p2;

  always_ff @(posedge gen_clk_i) begin
    if (reset_i) begin
      r_lock_cnt_p2 <= '0;
    end else if (r_vld_p1) begin
      if (!r_miss_p1 && in_tol(r_err_p1)) begin
        r_lock_cnt_p2 <= lock_inc_sat(r_lock_cnt_p2);
      end else begin
        r_lock_cnt_p2 <= '0;
      end
    end
  end

  assign error_o       = r_err_p1;
  assign error_valid_o = r_vld_p1;
  assign lock_o        = (r_lock_cnt_p2 == LOCK_FULL);

endmodule

// File: doc/phase_error_detector.md
Name: phase_error_detector

Overview:
- Upstream neighbour of the ADPLL PI loop filter; its output drives the loop filter's signed error input directly.
- Samples the reference clock and the DCO feedback clock in the gen_clk domain and measures, in gen_clk cycles, how far one rising edge leads the other.
- Emits a signed, saturated phase error per reference/feedback edge pair, plus a lock indicator.

Parameters:
- ERROR_WIDTH, 5, width of signed error_o; must equal the loop filter error width.
- SYNC_STAGES, 2, synchroniser flops per sampled clock input (minimum 2).
- LOCK_TOL, 1, largest |error| that counts as an in-lock measurement.
- LOCK_CYCLES, 8, consecutive in-lock measurements required to assert lock_o.

Ports:
- gen_clk_i  in  1  system clock; all logic on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- ref_clk_i  in  1  reference clock; asynchronous to gen_clk_i.
- fb_clk_i  in  1  DCO feedback clock; asynchronous to gen_clk_i.
- error_o  out  ERROR_WIDTH  signed phase error; positive means ref leads fb (DCO too slow).
- error_valid_o  out  1  one-cycle pulse marking a new measurement.
- lock_o  out  1  loop-locked indicator.

Behaviour:
- One clock, gen_clk_i. Reset is synchronous and active-high on reset_i; it takes priority over every other action.
- Reset values: error_o=0, error_valid_o=0, lock_o=0, FSM=IDLE, count=0, lock counter=0, synchroniser and edge-history flops=0.
- Input path: each clock input passes through SYNC_STAGES flops and a one-flop edge history. A rise is sync_out & ~hist. Both paths have identical latency, so it cancels in the measurement.
- MAX = 2^(ERROR_WIDTH-1)-1 (15 at default). Count is unsigned and saturates at MAX.
- FSM states are IDLE, REF_LEAD and FB_LEAD:
  - IDLE, both rises: measure 0, stay IDLE.
  - IDLE, ref rise only: go to REF_LEAD, count=1.
  - IDLE, fb rise only: go to FB_LEAD, count=1.
  - REF_LEAD, no rise: count=min(count+1, MAX).
  - REF_LEAD, fb rise only: measure +count, go to IDLE.
  - REF_LEAD, ref rise only (fb edge missed): measure +MAX, stay in REF_LEAD, count=1.
  - REF_LEAD, both rises: measure +count, stay in REF_LEAD, count=1. The fb rise closes the current interval and the ref rise opens a new one.
  - FB_LEAD mirrors REF_LEAD with the roles swapped and the measured value negated (-count, -MAX). Most negative output is -MAX; -2^(ERROR_WIDTH-1) is never produced.
- Output timing: a measurement is registered. error_valid_o=1 and error_o=value appear on the cycle after the closing rise is detected.
- Between measurements, error_valid_o=0 and error_o=0, so the downstream integrator accumulates only once per measurement.
- Lock counter:
  - On each measurement with |value| <= LOCK_TOL, the counter increments, saturating at LOCK_CYCLES.
  - On any other measurement, the counter clears and lock_o deasserts on the next cycle.
  - lock_o=1 while the counter equals LOCK_CYCLES.
  - A missed edge (±MAX) always clears the counter.
- Reset asserted mid-measurement: FSM returns to IDLE, any partial count is discarded and no measurement is emitted.

Optional Feature:
- Macro: PHASE_ERROR_HOLD_EN.
- Defined: error_o holds the last measured value until the next measurement; error_valid_o still pulses once per measurement. This suits a filter that samples on error_valid_o.
- Undefined: error_o is 0 on every cycle where error_valid_o=0, as in the Behaviour section.
- Reset clears error_o to 0 in both builds.

Decomposition:
- Shared package adpll_pkg:
  - FSM state enum (IDLE, REF_LEAD, FB_LEAD).
  - Default ERROR_WIDTH.
  - Function computing MAX from a width.
  - Magnitude/saturation helper, reused by the loop filter and the DCO.
- Sub-module edge_sync: SYNC_STAGES synchroniser plus rising-edge detector, with synchronous active-high reset. Instantiated twice, once per clock input.

Test Plan:
- Reset and idle: hold reset_i high for 3 cycles, then release with both clocks static -> all outputs 0 for 20 cycles.
- Ref leads: ref rises 4 gen_clk cycles before fb -> exactly one error_valid_o pulse with error_o=+4, then error_o=0.
- Fb leads and simultaneity: fb rises 6 cycles before ref -> error_o=-6. Then both rise on the same gen_clk cycle -> error_o=0 with valid pulse.
- Saturation and missed edge: ref rise, fb absent for 40 cycles, second ref rise -> error_o=+15 (MAX). Subsequent fb rise 3 cycles later -> error_o=+3.
- Lock: 8 consecutive pairs with offsets within ±1 -> lock_o rises one cycle after the 8th valid. Next pair with offset 5 -> lock_o falls the cycle after that valid. Assert reset mid-REF_LEAD -> no valid pulse emitted.
- PHASE_ERROR_HOLD_EN build: offsets +4, then -2 -> error_o holds +4 until the -2 measurement, then holds -2.
